// File: rtl/alu_operand_entry_pkg.sv
// Shared types and constants for the board-side ALU operand entry block.
package alu_operand_entry_pkg;

    localparam int unsigned ALUOP_W = 4;

    // Pushbutton roles, indexed into KEY[3:0]
    localparam int unsigned KEY_LO    = 0;
    localparam int unsigned KEY_HI    = 1;
    localparam int unsigned KEY_NEXT  = 2;
    localparam int unsigned KEY_ABORT = 3;

    typedef enum logic [1:0] {
        ENTER_A  = 2'd0,
        ENTER_B  = 2'd1,
        ENTER_OP = 2'd2,
        ISSUE    = 2'd3
    } entry_state_t;

endpackage

// File: rtl/alu_operand_entry_if.sv
// Operation handshake between the entry block (master) and the ALU wrapper (slave).
interface alu_operand_entry_if #(
    parameter int DW = 32
) ();
    import alu_operand_entry_pkg::*;

    logic [DW-1:0]      porta;
    logic [DW-1:0]      portb;
    logic [ALUOP_W-1:0] aluop;
    logic               op_valid;
    logic               op_ready;

    modport master (
        output porta, portb, aluop, op_valid,
        input  op_ready
    );

    modport slave (
        input  porta, portb, aluop, op_valid,
        output op_ready
    );

endinterface

// File: rtl/alu_operand_entry_key_debounce.sv
// One pushbutton: 2-flop synchronizer, stability counter and a press pulse
// on the debounced 1->0 transition.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= '1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // Flip only after DEBOUNCE_CYCLES consecutive differing samples
                level <= sync[1];
                cnt   <= '0;
                press <= level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_operand_entry.sv
// Assembles porta/portb/aluop from switches under debounced key control and
// offers the finished operation over a valid/ready handshake.
module alu_operand_entry
    import alu_operand_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DW              = 32
) (
    input  logic                       CLOCK_50,
    input  logic                       nRST,
    input  logic [3:0]                 KEY,
    input  logic [15:0]                SW,
    alu_operand_entry_if.master        op,
    output logic [1:0]                 entry_state
);
    logic [3:0]   press;
    entry_state_t state;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (CLOCK_50),
            .rst_n (nRST),
            .key   (KEY[i]),
            .press (press[i])
        );
    end

    assign op.op_valid = (state == ISSUE);
    assign entry_state = state;

    // Only the highest-priority press acts: abort > next > hi > lo
    always_ff @(posedge CLOCK_50) begin
        if (!nRST) begin
            state    <= ENTER_A;
            op.porta <= '0;
            op.portb <= '0;
            op.aluop <= '0;
        end else if (press[KEY_ABORT]) begin
            state    <= ENTER_A;
            op.porta <= '0;
            op.portb <= '0;
            op.aluop <= '0;
        end else begin
            unique case (state)
                ENTER_A: begin
                    if (press[KEY_NEXT])
                        state <= ENTER_B;
                    else if (press[KEY_HI])
                        op.porta[DW-1:DW/2] <= SW;
                    else if (press[KEY_LO])
                        op.porta[DW/2-1:0] <= SW;
                end
                ENTER_B: begin
                    if (press[KEY_NEXT])
                        state <= ENTER_OP;
                    else if (press[KEY_HI])
                        op.portb[DW-1:DW/2] <= SW;
                    else if (press[KEY_LO])
                        op.portb[DW/2-1:0] <= SW;
                end
                ENTER_OP: begin
                    if (press[KEY_NEXT])
                        state <= ISSUE;
                    else if (press[KEY_LO] && !press[KEY_HI])
                        op.aluop <= SW[ALUOP_W-1:0];
                end
                ISSUE: begin
                    if (op.op_ready)
                        state <= ENTER_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_entry.sv
// Scoreboard bench for alu_operand_entry with DEBOUNCE_CYCLES=4.
module tb_alu_operand_entry;
    import alu_operand_entry_pkg::*;

    logic        clk = 1'b0;
    logic        nrst;
    logic [3:0]  key;
    logic [15:0] sw;
    logic [1:0]  entry_state;

    always #5 clk = ~clk;

    alu_operand_entry_if bus ();

    alu_operand_entry #(
        .DEBOUNCE_CYCLES(4),
        .DW(32)
    ) dut (
        .CLOCK_50    (clk),
        .nRST        (nrst),
        .KEY         (key),
        .SW          (sw),
        .op          (bus),
        .entry_state (entry_state)
    );

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [1:0]  st;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;
    logic [1:0]  m_st;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int at, input string nm);
        exp_q.push_back('{at, nm, m_a, m_b, m_op, m_st});
    endtask

    function automatic void model_reset();
        m_a = '0; m_b = '0; m_op = '0; m_st = 2'd0;
    endfunction

    function automatic void apply(input logic [3:0] mask, input logic [15:0] v);
        if (mask[3]) begin
            model_reset();
        end else if (mask[2]) begin
            if (m_st != 2'd3) m_st = m_st + 2'd1;
        end else if (mask[1]) begin
            if (m_st == 2'd0) m_a[31:16] = v;
            else if (m_st == 2'd1) m_b[31:16] = v;
        end else if (mask[0]) begin
            if (m_st == 2'd0) m_a[15:0] = v;
            else if (m_st == 2'd1) m_b[15:0] = v;
            else if (m_st == 2'd2) m_op = v[3:0];
        end
    endfunction

    // Press keys in mask for 8 cycles, then release and let the release settle.
    // Effect must appear exactly 7 edges after the raw fall, not 6.
    task automatic press(input logic [3:0] mask, input logic [15:0] v, input string nm);
        int n;
        n   = cyc;
        sw  = v;
        key = ~mask;
        expect_at(n + 6, {nm, "_pre"});
        apply(mask, v);
        expect_at(n + 7, nm);
        repeat (8) tick();
        key = 4'hF;
        repeat (8) tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            tests++;
            if (e.cyc != cyc || bus.porta !== e.a || bus.portb !== e.b ||
                bus.aluop !== e.op || bus.op_valid !== (e.st == 2'd3) ||
                entry_state !== e.st) begin
                fails++;
                $display("FAIL %s cyc=%0d(due %0d): got a=%h b=%h op=%h v=%b st=%0d, want a=%h b=%h op=%h v=%b st=%0d",
                         e.name, cyc, e.cyc, bus.porta, bus.portb, bus.aluop, bus.op_valid,
                         entry_state, e.a, e.b, e.op, (e.st == 2'd3), e.st);
            end
        end
    end

    initial begin
        int n;
        nrst = 1'b0;
        key  = 4'hF;
        sw   = '0;
        bus.op_ready = 1'b0;
        model_reset();

        repeat (3) tick();
        expect_at(cyc, "reset");
        tick();
        nrst = 1'b1;
        tick();

        // Held KEY0: one event only, fixed latency
        n = cyc;
        sw = 16'h1234;
        key[0] = 1'b0;
        expect_at(n + 6, "t1_pre");
        apply(4'b0001, 16'h1234);
        expect_at(n + 7, "t1_porta");
        repeat (8) tick();
        sw = 16'h5678;
        repeat (10) tick();
        expect_at(cyc, "t1_held_once");
        key = 4'hF;
        repeat (8) tick();

        // 3-cycle glitch must not register
        n = cyc;
        sw = 16'h9999;
        key[0] = 1'b0;
        repeat (3) tick();
        key = 4'hF;
        expect_at(n + 8, "glitch_a");
        expect_at(n + 12, "glitch_b");
        repeat (14) tick();

        // Full entry
        press(4'b0010, 16'hBEEF, "a_hi");
        press(4'b0001, 16'hCAFE, "a_lo");
        press(4'b0100, 16'h0000, "to_b");
        press(4'b0001, 16'h0001, "b_lo");
        press(4'b0100, 16'h0000, "to_op");
        press(4'b0001, 16'h0003, "op_set");
        press(4'b0100, 16'h0000, "to_issue");
        expect_at(cyc, "issue_state");

        // ISSUE: operands frozen while op_ready=0
        press(4'b0001, 16'hFFFF, "issue_lo_ignored");
        press(4'b0010, 16'hAAAA, "issue_hi_ignored");
        press(4'b0100, 16'h0000, "issue_next_ignored");

        n = cyc;
        expect_at(n, "pre_handshake");
        bus.op_ready = 1'b1;
        tick();
        bus.op_ready = 1'b0;
        m_st = 2'd0;
        expect_at(n + 1, "handshake");
        tick();

        bus.op_ready = 1'b1;
        repeat (3) tick();
        expect_at(cyc, "ready_outside_issue");
        bus.op_ready = 1'b0;
        tick();

        // Abort beats next in the same cycle
        press(4'b0100, 16'h0000, "to_b_2");
        press(4'b1100, 16'h0000, "abort_vs_next");

        // Reset during a partial KEY0 count in ENTER_OP
        press(4'b0001, 16'h00AB, "a_lo_2");
        press(4'b0100, 16'h0000, "to_b_3");
        press(4'b0001, 16'h00CD, "b_lo_2");
        press(4'b0100, 16'h0000, "to_op_2");
        press(4'b0001, 16'h0005, "op_set_2");
        n = cyc;
        sw = 16'h0007;
        key[0] = 1'b0;
        repeat (3) tick();
        nrst = 1'b0;
        tick();
        model_reset();
        expect_at(n + 4, "mid_reset");
        nrst = 1'b1;
        expect_at(n + 10, "post_reset_pre");
        apply(4'b0001, 16'h0007);
        expect_at(n + 11, "post_reset_press");
        repeat (8) tick();
        key = 4'hF;
        repeat (8) tick();

        repeat (4) tick();
        if (exp_q.size() != 0) begin
            $display("FAIL pending_checks: got %0d unchecked, want 0", exp_q.size());
            tests += exp_q.size();
            fails += exp_q.size();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_operand_entry.md
Name: alu_operand_entry

Overview:
- Input-side companion to the ALU FPGA display wrapper. Where the wrapper drives results out to the HEX displays, this block takes user input from the board.
- Debounces the pushbuttons and assembles full 32-bit porta/portb operands plus a 4-bit aluop from the switches through a small entry state machine.
- Presents the completed operation to the ALU wrapper through a valid/ready handshake.
- Sits between the board pins (KEY, SW) and the ALU interface; the ALU result path and HEX display logic stay unchanged.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive stable synchronized samples needed to accept a key change (10 ms at 50 MHz).
- DW, 32, operand width; must be 32.

Ports:
- CLOCK_50  in  1  system clock.
- nRST  in  1  synchronous reset, active-low.
- KEY  in  4  raw pushbuttons, active-low (0 = pressed), asynchronous to CLOCK_50.
- SW  in  16  raw slide switches SW[15:0]; data for the operand halves and aluop.
- porta  out  32  assembled operand A.
- portb  out  32  assembled operand B.
- aluop  out  4  assembled ALU opcode.
- op_valid  out  1  the operation is complete and held stable.
- op_ready  in  1  consumer accepts the operation.
- entry_state  out  2  current state, for the LEDs.

Behaviour:
- Reset: when nRST=0 at a clock edge, the following all become 0:
  - porta, portb, aluop, op_valid;
  - entry_state (ENTER_A);
  - debounced key levels (held internally as 1 = released) and all debounce counters.
- Synchronizer: each KEY bit passes through a 2-flop synchronizer. SW is sampled directly at each use; it is quasi-static.
- Debounce, per key:
  - Counter resets to 0 whenever the synchronized sample equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and the sample still differs, the debounced level flips and the counter clears.
  - A press event is a single-cycle pulse on the cycle the debounced level goes 1->0. Release produces no event.
- Latency: a raw KEY fall that stays stable gives a press pulse DEBOUNCE_CYCLES+2 cycles later. Register updates land on the next edge.
- A glitch shorter than DEBOUNCE_CYCLES produces no event. A held key produces exactly one event.
- States, encoded 0..3: ENTER_A, ENTER_B, ENTER_OP, ISSUE. The target register is porta in ENTER_A and portb in ENTER_B.
- KEY0 press:
  - ENTER_A / ENTER_B: target[15:0] <= SW[15:0].
  - ENTER_OP: aluop <= SW[3:0].
  - ISSUE: ignored.
- KEY1 press:
  - ENTER_A / ENTER_B: target[31:16] <= SW[15:0].
  - ENTER_OP and ISSUE: ignored.
- KEY2 press:
  - Advances ENTER_A -> ENTER_B -> ENTER_OP -> ISSUE.
  - Ignored in ISSUE.
- KEY3 press: abort from any state. Clears porta, portb and aluop, drops op_valid, and returns to ENTER_A.
- ISSUE:
  - op_valid=1 combinationally from the state; porta, portb and aluop are frozen.
  - Handshake completes on an edge with op_valid & op_ready; next state is ENTER_A with operands retained, so a later issue can reuse them.
  - op_ready while not in ISSUE has no effect.
- Simultaneous press events in one cycle: priority KEY3 > KEY2 > KEY1 > KEY0. Only the highest-priority event acts; the others are dropped.
- KEY3 abort in ISSUE on the same edge as op_ready: the abort wins and the handshake is not counted.
- Reset mid-entry or mid-handshake: immediate return to reset values; pending debounce progress is discarded.
- Operands never change except via the events above.

Decomposition:
- Package alu_operand_entry_pkg holds:
  - entry_state_t enum {ENTER_A, ENTER_B, ENTER_OP, ISSUE}, 2 bits;
  - KEY_LO, KEY_HI, KEY_NEXT, KEY_ABORT index constants (0..3);
  - the aluop width constant.
- Sub-module key_debounce, instantiated 4 times: 2-flop synchronizer, counter, debounced level and press pulse, parameterized by DEBOUNCE_CYCLES.
- The top level contains the FSM and the operand registers.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then KEY0 falls and holds with SW=16'h1234 -> exactly one press pulse 6 cycles later; porta=32'h00001234 one cycle after; entry_state=0.
- KEY0 low for 3 cycles, then high -> no pulse; porta unchanged.
- Full entry:
  - ENTER_A: SW=16'hBEEF with KEY1, then SW=16'hCAFE with KEY0; KEY2.
  - ENTER_B: SW=16'h0001 with KEY0; KEY2.
  - ENTER_OP: SW=16'h0003 with KEY0; KEY2.
  - Required: porta=32'hBEEFCAFE, portb=32'h00000001, aluop=4'h3, op_valid=1, entry_state=3.
- In ISSUE, hold op_ready=0 for 10 cycles and press KEY0/KEY1 with new SW -> op_valid stays 1 and operands are unchanged. Then op_ready=1 for one cycle -> op_valid=0 next cycle, entry_state=0, operands retained.
- KEY2 and KEY3 press pulses arrive in the same cycle while in ENTER_B with porta nonzero -> abort wins: all operands 0, entry_state=0.
- nRST=0 asserted while in ENTER_OP during a partially counted KEY0 press -> all outputs 0 on the next edge. After nRST=1, the still-held KEY0 needs a full 6 cycles before its pulse.
